// File: rtl/packet_hex_streamer_pkg.sv
// Shared types and constants for the packet hex streamer.
// States, ASCII codes and packet byte-count helper.
package packet_hex_streamer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        EMIT_HI = 3'd2,
        EMIT_LO = 3'd3,
        CSUM_HI = 3'd4,
        CSUM_LO = 3'd5,
        TERM_CR = 3'd6,
        TERM_LF = 3'd7
    } state_t;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;

    function automatic int byte_count(input int bits);
        return bits / 8;
    endfunction

endpackage

// File: rtl/packet_hex_streamer_hex_nibble_encoder.sv
// Combinational 4-bit value to uppercase ASCII hex character.
// 0-9 -> '0'-'9', 10-15 -> 'A'-'F'.
module hex_nibble_encoder
    import packet_hex_streamer_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = ASCII_ZERO + {4'h0, nibble};
        if (nibble > 4'd9) begin
            ascii = ASCII_A + {4'h0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/packet_hex_streamer.sv
// Buffers one packet and streams it MSB-first as hex or raw bytes
// with a trailing checksum over a valid/ready byte interface.
module packet_hex_streamer
    import packet_hex_streamer_pkg::*;
#(
    parameter int PACKET_SIZE = 256,
    parameter bit BINARY      = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [PACKET_SIZE-1:0] pkt_data,
    input  logic                   pkt_valid,
    output logic                   pkt_ready,
    output logic [7:0]             tx_byte,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic                   overrun,
    input  logic                   overrun_clr
);

    localparam int NB = byte_count(PACKET_SIZE);
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    state_t                 state;
    logic [PACKET_SIZE-1:0] shadow;
    logic                   shadow_full;
    logic [PACKET_SIZE-1:0] shift;
    logic [PACKET_SIZE-1:0] shifted;
    logic [CW-1:0]          count;
    logic [7:0]             csum;
    logic [7:0]             csum_next;
    logic [3:0]             nibble;
    logic [7:0]             ascii;
    logic                   accept;
    logic                   take;
    logic                   drop;

    hex_nibble_encoder u_enc (
        .nibble (nibble),
        .ascii  (ascii)
    );

    assign accept    = tx_valid && tx_ready;
    // LOAD frees the shadow on this edge, so a same-cycle request fits.
    assign take      = enable && pkt_valid && (!shadow_full || state == LOAD);
    assign drop      = enable && pkt_valid && shadow_full && state != LOAD;
    assign pkt_ready = !shadow_full;
    assign busy      = (state != IDLE);

    // Character that follows the current one, prepared for the next edge.
    always_comb begin
        csum_next = csum + shift[PACKET_SIZE-1 -: 8];
        shifted   = shift << 8;
        nibble    = 4'h0;
        case (state)
            LOAD:    nibble = shadow[PACKET_SIZE-1 -: 4];
            EMIT_HI: nibble = shift[PACKET_SIZE-5 -: 4];
            EMIT_LO: nibble = (count == '0) ? csum_next[7:4]
                                            : shifted[PACKET_SIZE-1 -: 4];
            CSUM_HI: nibble = csum[3:0];
            default: nibble = 4'h0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shadow      <= '0;
            shadow_full <= 1'b0;
            shift       <= '0;
            count       <= '0;
            csum        <= '0;
            tx_byte     <= '0;
            tx_valid    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end

            if (!enable) begin
                state       <= IDLE;
                tx_valid    <= 1'b0;
                shadow_full <= 1'b0;
            end else begin
                if (take) begin
                    shadow      <= pkt_data;
                    shadow_full <= 1'b1;
                end else if (state == LOAD) begin
                    shadow_full <= 1'b0;
                end

                case (state)
                    IDLE: begin
                        if (shadow_full) begin
                            state <= LOAD;
                        end
                    end
                    LOAD: begin
                        shift    <= shadow;
                        csum     <= '0;
                        count    <= CW'(NB - 1);
                        tx_byte  <= BINARY ? shadow[PACKET_SIZE-1 -: 8]
                                           : ascii;
                        tx_valid <= 1'b1;
                        state    <= EMIT_HI;
                    end
                    EMIT_HI: begin
                        if (accept) begin
                            if (BINARY) begin
                                csum  <= csum_next;
                                shift <= shifted;
                                if (count == '0) begin
                                    state   <= CSUM_HI;
                                    tx_byte <= csum_next;
                                end else begin
                                    count   <= count - 1'b1;
                                    tx_byte <= shifted[PACKET_SIZE-1 -: 8];
                                end
                            end else begin
                                state   <= EMIT_LO;
                                tx_byte <= ascii;
                            end
                        end
                    end
                    EMIT_LO: begin
                        if (accept) begin
                            csum    <= csum_next;
                            shift   <= shifted;
                            tx_byte <= ascii;
                            if (count == '0) begin
                                state <= CSUM_HI;
                            end else begin
                                count <= count - 1'b1;
                                state <= EMIT_HI;
                            end
                        end
                    end
                    CSUM_HI: begin
                        if (accept) begin
                            if (BINARY) begin
                                tx_valid <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                tx_byte <= ascii;
                                state   <= CSUM_LO;
                            end
                        end
                    end
                    CSUM_LO: begin
                        if (accept) begin
                            tx_byte <= ASCII_CR;
                            state   <= TERM_CR;
                        end
                    end
                    TERM_CR: begin
                        if (accept) begin
                            tx_byte <= ASCII_LF;
                            state   <= TERM_LF;
                        end
                    end
                    TERM_LF: begin
                        if (accept) begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                    default: begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
